instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
Fetch-side reader for the instruction memory. It drives the memory's read address from a PC register and tracks the 1-cycle synchronous read latency. It presents each fetched word to decode with a valid/ready handshake and handles decode stalls, branch/jump redirects, and an error halt. It never writes memory; the memory's write port stays with the testbench loader.

Parameters:
WIDTH1, 32, data/address width (matches instruction memory)
MEM_SIZE, 1024, instruction memory depth in words; bound for fetch address check
RESET_PC, 0, byte PC loaded on reset (word-aligned)

Ports:
clk  input  1  clock, all state on posedge
reset  input  1  synchronous, active-high
fetch_en  input  1  permit new fetches; held low while loader writes memory
imem_addr  output  WIDTH1  word index to instruction memory (byte PC >> 2, zero-extended)
imem_rdata  input  WIDTH1  memory read data, valid 1 cycle after address
if_valid  output  1  if_instr/if_pc valid this cycle
if_instr  output  WIDTH1  fetched instruction (= imem_rdata)
if_pc  output  WIDTH1  byte PC of if_instr
id_ready  input  1  decode accepts word when if_valid && id_ready
redirect_valid  input  1  one-cycle redirect request
redirect_pc  input  WIDTH1  byte target PC
fetch_err  output  1  sticky error (misaligned redirect or out-of-range fetch)
halted  output  1  high in HALT state

Behaviour:
- Registers: state {IDLE, RUN, HALT}, fetch_pc (next byte PC to issue), resp_pc (PC of word in imem_rdata), resp_valid, fetch_err.
- Reset (synchronous, any state, mid-operation included): state=IDLE, fetch_pc=RESET_PC, resp_pc=RESET_PC, resp_valid=0, fetch_err=0. Outputs: if_valid=0, halted=0, imem_addr=RESET_PC>>2.
- if_valid = resp_valid && !redirect_valid && state!=HALT. if_instr = imem_rdata. if_pc = resp_pc.
- stall = resp_valid && !id_ready.
- imem_addr mux, in priority order:
  - redirect_valid: redirect_pc>>2
  - stall: resp_pc>>2, which re-reads the same word so the data stays stable
  - otherwise: fetch_pc>>2
- An issue occurs in RUN when fetch_en=1, not stalled, and the address is legal. Legal means fetch_pc[1:0]==0 and fetch_pc>>2 < MEM_SIZE. On issue: resp_pc<=fetch_pc, resp_valid<=1, fetch_pc<=fetch_pc+4 (mod 2^32).
- Accept without issue (fetch_en=0): resp_valid<=0.
- Stall: fetch_pc, resp_pc and resp_valid are held. Latency from issue to if_valid is exactly 1 cycle. Back-to-back throughput is 1 word/cycle.
- Redirect has priority over stall and normal issue, in any of IDLE/RUN:
  - The presented word is killed (if_valid=0 that cycle; not counted as accepted).
  - Aligned and in range, state RUN with fetch_en=1: resp_pc<=redirect_pc, resp_valid<=1, fetch_pc<=redirect_pc+4.
  - Aligned and in range, state IDLE or fetch_en=0: fetch_pc<=redirect_pc, resp_valid<=0.
  - Misaligned (redirect_pc[1:0]!=0) or out of range: fetch_err<=1, resp_valid<=0, state<=HALT.
- Out-of-range sequential issue (fetch_pc>>2 >= MEM_SIZE): fetch_err<=1, resp_valid<=0, state<=HALT. No wrap to word 0.
- State transitions:
  - IDLE->RUN when fetch_en=1. The first issue happens the same cycle the state becomes RUN, i.e. the cycle fetch_en is sampled high.
  - RUN->IDLE when fetch_en=0 and !stall. An outstanding stalled word is held until accepted, then the state drops to IDLE. fetch_pc is retained, so re-enabling resumes sequentially.
  - HALT: exited only by reset; inputs are ignored and imem_addr holds its last value.
- Simultaneous redirect_valid && id_ready && resp_valid: the word is NOT accepted (killed); only the redirect takes effect.

Test Plan:
- Sequential: load words 0..3 = 0x11,0x22,0x33,0x44; reset; fetch_en=1; id_ready=1 -> if_valid from 2nd cycle after reset release; (if_pc,if_instr) = (0,0x11),(4,0x22),(8,0x33),(12,0x44) on consecutive cycles.
- Stall: at if_pc=4 drop id_ready for 3 cycles -> if_pc=4, if_instr=0x22 held stable all 3 cycles; imem_addr=1; next accepted word is (8,0x33), no skip or duplicate.
- Redirect: while (8,0x33) is presented, assert redirect_valid with redirect_pc=0x40 (word 16=0xAA) -> if_valid=0 that cycle; next cycle (0x40,0xAA); then (0x44, word 17).
- Misaligned redirect_pc=0x42 -> next cycle fetch_err=1, halted=1, if_valid=0 permanently; reset -> fetch_err=0, state IDLE, fetch_pc=0.
- Bound: MEM_SIZE=8, run sequentially -> words 0..7 delivered; fetch of PC 0x20 sets fetch_err=1, halted=1, no wrap to word 0.
- Reset mid-stream, plus fetch_en gating: assert reset while if_pc=8 and stalled -> if_valid=0 next cycle, restart at PC 0. Separately, drop fetch_en during a stall -> the held word is delivered once, then if_valid=0; re-raise fetch_en -> resumes at the next sequential PC.

Source files
------------

// File: rtl/instruction_fetch.sv
// Fetch-side reader for a synchronous-read instruction memory.
// Issues word addresses from a byte PC and presents fetched words to decode with valid/ready.
module instruction_fetch #(
  parameter int unsigned       WIDTH1   = 32,
  parameter int unsigned       MEM_SIZE = 1024,
  parameter logic [WIDTH1-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_en,
  output logic [WIDTH1-1:0] imem_addr,
  input  logic [WIDTH1-1:0] imem_rdata,
  output logic              if_valid,
  output logic [WIDTH1-1:0] if_instr,
  output logic [WIDTH1-1:0] if_pc,
  input  logic              id_ready,
  input  logic              redirect_valid,
  input  logic [WIDTH1-1:0] redirect_pc,
  output logic              fetch_err,
  output logic              halted
);

  typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

  localparam logic [WIDTH1-1:0] MemWords = WIDTH1'(MEM_SIZE);
  localparam logic [WIDTH1-1:0] PcStep   = WIDTH1'(4);
  localparam logic [WIDTH1-1:0] ResetIdx = {2'b00, RESET_PC[WIDTH1-1:2]};

  function automatic logic [WIDTH1-1:0] word_idx(input logic [WIDTH1-1:0] pc);
    return {2'b00, pc[WIDTH1-1:2]};
  endfunction

  function automatic logic pc_legal(input logic [WIDTH1-1:0] pc);
    return (pc[1:0] == 2'b00) && (word_idx(pc) < MemWords);
  endfunction

  state_e            state_q, state_d;
  logic [WIDTH1-1:0] fetch_pc_q, fetch_pc_d;
  logic [WIDTH1-1:0] resp_pc_q, resp_pc_d;
  logic              resp_valid_q, resp_valid_d;
  logic              fetch_err_q, fetch_err_d;
  logic              halted_q, halted_d;
  logic [WIDTH1-1:0] last_addr_q, last_addr_d;

  logic stall;
  logic redirect_ok;
  logic fetch_ok;

  assign stall       = resp_valid_q && !id_ready;
  assign redirect_ok = pc_legal(redirect_pc);
  assign fetch_ok    = pc_legal(fetch_pc_q);

  assign if_valid  = resp_valid_q && !redirect_valid && (state_q != StHalt);
  assign if_instr  = imem_rdata;
  assign if_pc     = resp_pc_q;
  assign fetch_err = fetch_err_q;
  assign halted    = halted_q;

  // A stall re-reads the presented word so imem_rdata stays stable for decode.
  always_comb begin
    imem_addr = word_idx(fetch_pc_q);
    if (state_q == StHalt) begin
      imem_addr = last_addr_q;
    end else if (redirect_valid) begin
      imem_addr = word_idx(redirect_pc);
    end else if (stall) begin
      imem_addr = word_idx(resp_pc_q);
    end
  end

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    resp_pc_d    = resp_pc_q;
    resp_valid_d = resp_valid_q;
    fetch_err_d  = fetch_err_q;
    last_addr_d  = imem_addr;

    if (state_q != StHalt) begin
      if (redirect_valid) begin
        // The presented word is killed whatever id_ready says.
        if (!redirect_ok) begin
          fetch_err_d  = 1'b1;
          resp_valid_d = 1'b0;
          state_d      = StHalt;
        end else if ((state_q == StRun) && fetch_en) begin
          resp_pc_d    = redirect_pc;
          resp_valid_d = 1'b1;
          fetch_pc_d   = redirect_pc + PcStep;
        end else begin
          fetch_pc_d   = redirect_pc;
          resp_valid_d = 1'b0;
          state_d      = fetch_en ? StRun : StIdle;
        end
      end else if (stall) begin
        state_d = state_q;
      end else if (fetch_en) begin
        if (fetch_ok) begin
          resp_pc_d    = fetch_pc_q;
          resp_valid_d = 1'b1;
          fetch_pc_d   = fetch_pc_q + PcStep;
          state_d      = StRun;
        end else begin
          fetch_err_d  = 1'b1;
          resp_valid_d = 1'b0;
          state_d      = StHalt;
        end
      end else begin
        resp_valid_d = 1'b0;
        state_d      = StIdle;
      end
    end

    halted_d = (state_d == StHalt);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      fetch_pc_q   <= RESET_PC;
      resp_pc_q    <= RESET_PC;
      resp_valid_q <= 1'b0;
      fetch_err_q  <= 1'b0;
      halted_q     <= 1'b0;
      last_addr_q  <= ResetIdx;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      resp_pc_q    <= resp_pc_d;
      resp_valid_q <= resp_valid_d;
      fetch_err_q  <= fetch_err_d;
      halted_q     <= halted_d;
      last_addr_q  <= last_addr_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: sequential fetch, stall, redirect, error halt,
// reset mid-stream, fetch_en gating, and the memory-size bound on a small instance.
module tb_instruction_fetch;

  logic        clk;
  logic        reset, fetch_en, id_ready, redirect_valid;
  logic [31:0] redirect_pc, imem_addr, imem_rdata, if_instr, if_pc;
  logic        if_valid, fetch_err, halted;

  logic        reset_b, fetch_en_b, id_ready_b, redirect_valid_b;
  logic [31:0] redirect_pc_b, imem_addr_b, imem_rdata_b, if_instr_b, if_pc_b;
  logic        if_valid_b, fetch_err_b, halted_b;

  logic [31:0] mem [0:1023];
  int checks = 0;
  int errors = 0;

  instruction_fetch u_dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_ready(id_ready), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_err(fetch_err), .halted(halted)
  );

  instruction_fetch #(.MEM_SIZE(8)) u_small (
    .clk(clk), .reset(reset_b), .fetch_en(fetch_en_b), .imem_addr(imem_addr_b),
    .imem_rdata(imem_rdata_b), .if_valid(if_valid_b), .if_instr(if_instr_b), .if_pc(if_pc_b),
    .id_ready(id_ready_b), .redirect_valid(redirect_valid_b), .redirect_pc(redirect_pc_b),
    .fetch_err(fetch_err_b), .halted(halted_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memory model shared by both instances.
  always @(posedge clk) begin
    if (imem_addr < 32'd1024) imem_rdata <= mem[imem_addr[9:0]];
    else                      imem_rdata <= 32'hDEAD_BEEF;
    if (imem_addr_b < 32'd1024) imem_rdata_b <= mem[imem_addr_b[9:0]];
    else                        imem_rdata_b <= 32'hDEAD_BEEF;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [31:0] pc, input logic [31:0] instr);
    chk({tag, "_valid"}, {31'd0, if_valid}, 32'd1);
    chk({tag, "_pc"}, if_pc, pc);
    chk({tag, "_instr"}, if_instr, instr);
  endtask

  task automatic start_main();
    reset = 1'b1; fetch_en = 1'b0; id_ready = 1'b1; redirect_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0; fetch_en = 1'b1;
    tick();
  endtask

  logic [31:0] small_exp [0:7];

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hF000_0000 | i;
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
    mem[4] = 32'h55; mem[5] = 32'h66; mem[6] = 32'h77; mem[7] = 32'h88;
    mem[16] = 32'hAA; mem[17] = 32'hBB;
    small_exp[0] = 32'h11; small_exp[1] = 32'h22; small_exp[2] = 32'h33; small_exp[3] = 32'h44;
    small_exp[4] = 32'h55; small_exp[5] = 32'h66; small_exp[6] = 32'h77; small_exp[7] = 32'h88;

    reset_b = 1'b1; fetch_en_b = 1'b0; id_ready_b = 1'b1;
    redirect_valid_b = 1'b0; redirect_pc_b = 32'd0;
    reset = 1'b1; fetch_en = 1'b0; id_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0;

    // Reset state
    tick();
    tick();
    chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_fetch_err", {31'd0, fetch_err}, 32'd0);
    chk("rst_imem_addr", imem_addr, 32'd0);

    // Sequential fetch
    reset = 1'b0; fetch_en = 1'b1;
    #1;
    chk("seq_first_addr", imem_addr, 32'd0);
    chk("seq_c0_valid", {31'd0, if_valid}, 32'd0);
    tick();
    chk_word("seq0", 32'd0, 32'h11);
    chk("seq0_addr", imem_addr, 32'd1);
    tick();
    chk_word("seq1", 32'd4, 32'h22);
    tick();
    chk_word("seq2", 32'd8, 32'h33);
    tick();
    chk_word("seq3", 32'd12, 32'h44);

    // Stall for 3 cycles at pc 4, then redirect to 0x40
    start_main();
    chk_word("st0", 32'd0, 32'h11);
    tick();
    id_ready = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk_word($sformatf("stall%0d", k), 32'd4, 32'h22);
      chk($sformatf("stall%0d_addr", k), imem_addr, 32'd1);
      tick();
    end
    id_ready = 1'b1;
    #1;
    chk_word("stall_release", 32'd4, 32'h22);
    chk("stall_release_addr", imem_addr, 32'd2);
    tick();
    chk_word("after_stall", 32'd8, 32'h33);
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    #1;
    chk("redir_kill", {31'd0, if_valid}, 32'd0);
    chk("redir_addr", imem_addr, 32'd16);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk_word("redir_tgt", 32'h40, 32'hAA);
    chk("redir_tgt_addr", imem_addr, 32'd17);
    tick();
    chk_word("redir_next", 32'h44, 32'hBB);

    // Misaligned redirect halts until reset
    redirect_valid = 1'b1; redirect_pc = 32'h42;
    #1;
    chk("mis_kill", {31'd0, if_valid}, 32'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("mis_err", {31'd0, fetch_err}, 32'd1);
    chk("mis_halted", {31'd0, halted}, 32'd1);
    chk("mis_valid", {31'd0, if_valid}, 32'd0);
    chk("mis_addr_hold", imem_addr, 32'd16);
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    tick();
    chk("halt_ignore_valid", {31'd0, if_valid}, 32'd0);
    chk("halt_ignore_halted", {31'd0, halted}, 32'd1);
    chk("halt_ignore_addr", imem_addr, 32'd16);
    redirect_valid = 1'b0;
    tick();
    chk("halt_still_valid", {31'd0, if_valid}, 32'd0);
    reset = 1'b1;
    tick();
    chk("rst2_err", {31'd0, fetch_err}, 32'd0);
    chk("rst2_halted", {31'd0, halted}, 32'd0);
    chk("rst2_valid", {31'd0, if_valid}, 32'd0);
    chk("rst2_addr", imem_addr, 32'd0);

    // Reset while stalled at pc 8
    start_main();
    tick();
    tick();
    id_ready = 1'b0;
    #1;
    chk_word("rms_stall", 32'd8, 32'h33);
    chk("rms_stall_addr", imem_addr, 32'd2);
    tick();
    reset = 1'b1;
    tick();
    chk("rms_valid", {31'd0, if_valid}, 32'd0);
    chk("rms_addr", imem_addr, 32'd0);
    reset = 1'b0; id_ready = 1'b1;
    tick();
    chk_word("rms_restart", 32'd0, 32'h11);

    // Drop fetch_en during a stall: held word delivered once, then resume
    tick();
    id_ready = 1'b0; fetch_en = 1'b0;
    #1;
    chk_word("gate_stall", 32'd4, 32'h22);
    chk("gate_stall_addr", imem_addr, 32'd1);
    tick();
    id_ready = 1'b1;
    #1;
    chk_word("gate_deliver", 32'd4, 32'h22);
    tick();
    chk("gate_idle_valid", {31'd0, if_valid}, 32'd0);
    chk("gate_idle_addr", imem_addr, 32'd2);
    tick();
    chk("gate_idle2_valid", {31'd0, if_valid}, 32'd0);
    fetch_en = 1'b1;
    tick();
    chk_word("gate_resume0", 32'd8, 32'h33);
    tick();
    chk_word("gate_resume1", 32'd12, 32'h44);

    // Memory-size bound on the 8-word instance
    reset_b = 1'b0; fetch_en_b = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("bnd%0d_valid", k), {31'd0, if_valid_b}, 32'd1);
      chk($sformatf("bnd%0d_pc", k), if_pc_b, 32'(4 * k));
      chk($sformatf("bnd%0d_instr", k), if_instr_b, small_exp[k]);
      chk($sformatf("bnd%0d_err", k), {31'd0, fetch_err_b}, 32'd0);
      tick();
    end
    chk("bnd_err", {31'd0, fetch_err_b}, 32'd1);
    chk("bnd_halted", {31'd0, halted_b}, 32'd1);
    chk("bnd_valid", {31'd0, if_valid_b}, 32'd0);
    chk("bnd_addr", imem_addr_b, 32'd8);
    tick();
    chk("bnd_nowrap_valid", {31'd0, if_valid_b}, 32'd0);
    chk("bnd_nowrap_addr", imem_addr_b, 32'd8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
